// File: rtl/param_sram_ctrl.sv
// Single-port synchronous SRAM with byte-lane writes, 1- or 2-cycle read latency,
// and a zero-fill clear engine that runs after reset or on request.
module param_sram_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    drop_err
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_fire;
    logic                  wr_fire;

    always_comb begin
        busy    = (state == CLEAR);
        rd_fire = en && !we && !busy;
        wr_fire = en &&  we && !busy;
        rd_word = mem[addr];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr) state_next = CLEAR;
            CLEAR:   if (cnt == CNT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt wraps to 0 on the edge that clears the last word, matching the exit to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_err <= 1'b0;
        else if (en && busy) drop_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Read data is captured into the pipeline at the access edge, so later writes
    // and clears never disturb an in-flight read.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_data;
            logic                  s1_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_data    <= '0;
                    s1_valid   <= 1'b0;
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else begin
                    s1_valid   <= rd_fire;
                    if (rd_fire) s1_data <= rd_word;
                    dout_valid <= s1_valid;
                    if (s1_valid) dout <= s1_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else begin
                    dout_valid <= rd_fire;
                    if (rd_fire) dout <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_sram_ctrl.sv
// Scoreboard bench for param_sram_ctrl: an 8-bit latency-1 and a 32-bit latency-2
// instance share stimulus; a reference memory predicts every read result and its timing.
module tb_param_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, we, clr;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [3:0]  be;

    logic [7:0]  dout1;
    logic        dv1, busy1, derr1;
    logic [31:0] dout2;
    logic        dv2, busy2, derr2;

    always #5 clk = ~clk;

    param_sram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din[7:0]), .be(be[0]),
        .clr(clr), .dout(dout1), .dout_valid(dv1), .busy(busy1), .drop_err(derr1)
    );

    param_sram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut_lat2 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din), .be(be),
        .clr(clr), .dout(dout2), .dout_valid(dv2), .busy(busy2), .drop_err(derr2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [31:0] model [8];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each strobe must match the oldest expected read, on the exact expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL lat1_spurious: got strobe data=%h, expected no strobe", dout1);
                end else begin
                    e1 = q1.pop_front();
                    if (dout1 !== e1.data[7:0] || cyc != e1.due) begin
                        bad++;
                        $display("FAIL lat1_read: got %h at cycle %0d, expected %h at cycle %0d",
                                 dout1, cyc, e1.data[7:0], e1.due);
                    end
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                total++; bad++;
                $display("FAIL lat1_missing: got no strobe at cycle %0d, expected %h", cyc, q1[0].data[7:0]);
                q1.delete(0);
            end
            if (dv2) begin
                total++;
                if (q2.size() == 0) begin
                    bad++;
                    $display("FAIL lat2_spurious: got strobe data=%h, expected no strobe", dout2);
                end else begin
                    e2 = q2.pop_front();
                    if (dout2 !== e2.data || cyc != e2.due) begin
                        bad++;
                        $display("FAIL lat2_read: got %h at cycle %0d, expected %h at cycle %0d",
                                 dout2, cyc, e2.data, e2.due);
                    end
                end
            end else if (q2.size() != 0 && q2[0].due <= cyc) begin
                total++; bad++;
                $display("FAIL lat2_missing: got no strobe at cycle %0d, expected %h", cyc, q2[0].data);
                q2.delete(0);
            end
        end
    end

    task automatic idle(input int n);
        en = 1'b0; we = 1'b0; clr = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        en = 1'b1; we = 1'b1; clr = 1'b0; addr = a; din = d; be = b;
        for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [2:0] a);
        exp_t e;
        en = 1'b1; we = 1'b0; clr = 1'b0; addr = a; din = $urandom; be = 4'($urandom);
        e.data = {24'h0, model[a][7:0]}; e.due = cyc + 1; q1.push_back(e);
        e.data = model[a];               e.due = cyc + 2; q2.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        en = 1'b0; we = 1'b0; clr = 1'b0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 10) begin
            @(posedge clk); #1; n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d/%0d reads outstanding, expected 0/0", q1.size(), q2.size());
            q1.delete(); q2.delete();
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
        rst_n = 1'b0; en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; din = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({dout1, dv1, derr1, busy1} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_lat1: got dout=%h v=%b err=%b busy=%b, expected 00 0 0 1", dout1, dv1, derr1, busy1);
        end
        total++;
        if ({dout2, dv2, derr2, busy2} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_lat2: got dout=%h v=%b err=%b busy=%b, expected 0 0 0 1", dout2, dv2, derr2, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            exp_busy = (i < 8);
            total++;
            if ({busy1, busy2} !== {exp_busy, exp_busy}) begin
                bad++;
                $display("FAIL reset_busy_len: got busy=%b%b after %0d edges, expected %b", busy1, busy2, i, exp_busy);
            end
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic test_clear_contents();
        for (int a = 0; a < 8; a++) rd(3'(a));
        drain();
    endtask

    task automatic test_byte_write();
        wr(3'd3, 32'h000000A5, 4'b0001);
        rd(3'd3);
        drain();
        total++;
        if ({dout1, dout2} !== {8'hA5, 32'h000000A5}) begin
            bad++;
            $display("FAIL byte_write_a5: got %h/%h, expected a5/000000a5", dout1, dout2);
        end
        wr(3'd6, 32'h11223344, 4'hF);
        wr(3'd6, 32'hAABBCCDD, 4'b0101);
        wr(3'd6, 32'hFFFFFFFF, 4'b0000);
        rd(3'd6);
        drain();
        total++;
        if ({dout1, dout2, dv1, dv2} !== {8'hDD, 32'h11BB33DD, 2'b00}) begin
            bad++;
            $display("FAIL byte_lanes: got %h/%h v=%b%b, expected dd/11bb33dd v=00", dout1, dout2, dv1, dv2);
        end
    endtask

    task automatic test_back_to_back();
        wr(3'd1, 32'h00000010, 4'hF);
        wr(3'd2, 32'h00000020, 4'hF);
        wr(3'd3, 32'h00000030, 4'hF);
        rd(3'd1);
        rd(3'd2);
        rd(3'd3);
        wr(3'd5, 32'h5A5A5A5A, 4'hF);
        idle(1);
        rd(3'd5);
        wr(3'd5, 32'hC3C3C3C3, 4'hF);
        rd(3'd5);
        drain();
    endtask

    task automatic test_clr_drop();
        rd(3'd2);
        en = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; en = 1'b1; we = 1'b1; addr = 3'd4; din = 32'hDEADBEEF; be = 4'hF;
        @(posedge clk); #1;
        total++;
        if ({busy1, busy2, derr1, derr2} !== 4'b1111) begin
            bad++;
            $display("FAIL drop_write: got busy=%b%b err=%b%b, expected 11 11", busy1, busy2, derr1, derr2);
        end
        we = 1'b0; addr = 3'd2;
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clr = (i == 1);
            @(posedge clk); #1;
        end
        clr = 1'b0;
        total++;
        if ({busy1, busy2} !== 2'b11) begin
            bad++;
            $display("FAIL clr_busy_hold: got busy=%b%b before last clear edge, expected 11", busy1, busy2);
        end
        @(posedge clk); #1;
        total++;
        if ({busy1, busy2} !== 2'b00) begin
            bad++;
            $display("FAIL clr_busy_end: got busy=%b%b after 8 clear edges, expected 00", busy1, busy2);
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
        for (int a = 0; a < 8; a++) rd(3'(a));
        drain();
        total++;
        if ({derr1, derr2} !== 2'b11) begin
            bad++;
            $display("FAIL drop_sticky: got err=%b%b, expected 11", derr1, derr2);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic exp_busy;
        for (int a = 0; a < 8; a++) wr(3'(a), 32'h01010101 * (a + 1), 4'hF);
        rd(3'd7);
        drain();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dout1, dv1, derr1, busy1, dout2, dv2, derr2, busy2} !== {8'h00, 3'b001, 32'h0, 3'b001}) begin
            bad++;
            $display("FAIL midclear_reset: got %h %b%b%b / %h %b%b%b, expected 00 001 / 0 001",
                     dout1, dv1, derr1, busy1, dout2, dv2, derr2, busy2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            exp_busy = (i < 8);
            total++;
            if ({busy1, busy2} !== {exp_busy, exp_busy}) begin
                bad++;
                $display("FAIL midclear_busy_len: got busy=%b%b after %0d edges, expected %b", busy1, busy2, i, exp_busy);
            end
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
        for (int a = 0; a < 8; a++) rd(3'(a));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear_contents();
        test_byte_write();
        test_back_to_back();
        test_clr_drop();
        test_reset_mid_clear();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
